mips_muldiv_unit: RTL

- Parametrised multi-cycle multiply/divide unit that owns the HI/LO architectural registers.
- Replaces the single-cycle combinational product/quotient feeding HI/LO in the CPU.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the decode/execute stage and signals `busy` so the CPU stalls MFHI/MFLO and any further mult/div.
- Generalised to any even operand width.

---
 rtl/mips_muldiv_unit.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mips_muldiv_unit.sv
// Multi-cycle MIPS multiply/divide unit owning the HI/LO registers.
// Optional build macro MIPS_MULDIV_FAST_MUL_EN: single-pass combinational MULT/MULTU.
module mips_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   opa_q, opa_d;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   rem_q, rem_d;     // product high half / partial remainder
  logic [WIDTH-1:0]   quo_q, quo_d;     // multiplier / dividend, shifted into product low half / quotient
  logic               is_mul_q, is_mul_d;
  logic               prod_neg_q, prod_neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               divzero_q, divzero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               is_signed;
  logic [WIDTH-1:0]   a_op, b_op;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_raw;
  logic [2*WIDTH-1:0] prod_fix;

  assign is_signed = ~op[0];
  assign a_op      = (is_signed && a[WIDTH-1]) ? -a : a;
  assign b_op      = (is_signed && b[WIDTH-1]) ? -b : b;

  assign mul_sum   = {1'b0, rem_q} + (quo_q[0] ? {1'b0, opa_q} : {(WIDTH+1){1'b0}});
  assign div_trial = {rem_q, quo_q[WIDTH-1]};
  assign div_ge    = div_trial >= {1'b0, opa_q};
  // When the subtraction is taken the true difference fits in WIDTH bits.
  assign div_diff  = div_trial[WIDTH-1:0] - opa_q;

`ifdef MIPS_MULDIV_FAST_MUL_EN
  assign prod_raw = {{WIDTH{1'b0}}, opa_q} * {{WIDTH{1'b0}}, quo_q};
`else
  assign prod_raw = {rem_q, quo_q};
`endif
  assign prod_fix = prod_neg_q ? -prod_raw : prod_raw;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    opa_d      = opa_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    is_mul_d   = is_mul_q;
    prod_neg_d = prod_neg_q;
    rem_neg_d  = rem_neg_q;
    divzero_d  = divzero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            3'b100: hi_d = a;
            3'b101: lo_d = a;
            3'b000, 3'b001, 3'b010, 3'b011: begin
              opa_d      = op[1] ? b_op : a_op;
              quo_d      = op[1] ? a_op : b_op;
              rem_d      = '0;
              cnt_d      = '0;
              is_mul_d   = ~op[1];
              prod_neg_d = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
              rem_neg_d  = is_signed & a[WIDTH-1];
              divzero_d  = op[1] & (b == '0);
`ifdef MIPS_MULDIV_FAST_MUL_EN
              state_d    = op[1] ? S_DIV : S_FIX;
`else
              state_d    = op[1] ? S_DIV : S_MUL;
`endif
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        rem_d = mul_sum[WIDTH:1];
        quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
      end
      S_DIV: begin
        if (div_ge) begin
          rem_d = div_diff;
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = div_trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_mul_q) begin
          {hi_d, lo_d} = prod_fix;
        end else begin
          // Divide by zero leaves the whole dividend in the remainder; re-signing it restores a.
          hi_d = rem_neg_q ? -rem_q : rem_q;
          if (divzero_q) lo_d = '1;
          else           lo_d = prod_neg_q ? -quo_q : quo_q;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      opa_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      is_mul_q   <= 1'b0;
      prod_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      divzero_q  <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
    end else if (clk_enable) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      opa_q      <= opa_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      is_mul_q   <= is_mul_d;
      prod_neg_q <= prod_neg_d;
      rem_neg_q  <= rem_neg_d;
      divzero_q  <= divzero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
